timekeeper_bcd: RTL and testbench
=================================

# timekeeper_bcd

Parametrised BCD time-of-day core for the board-level digital clock: an internal prescaler derives a 1 Hz tick from the system clock, and cascaded seconds/minutes/hours counters advance on that tick. Compared with the previous clock block, it adds:

- run-time 12/24-hour display;
- single-step, edge-detected adjustment of any field, including alarm hour/minute;
- an alarm with a timed ring output.

It feeds the seven-segment scan driver directly.

## Interface
Parameters:
- TICK_DIV, 50000000, system clock cycles per second tick (minimum 2)
- ALARM_SECS, 60, number of ticks the alarm output stays asserted (1..255)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- cr  in  1  clear; reset is asynchronous and active-low
- adjust  in  1  1 = adjust mode: timekeeping frozen, step applies to selected field
- target  in  1  0 = adjust time registers, 1 = adjust alarm registers
- field  in  2  00 seconds, 01 minutes, 10 hours, 11 no-op
- step  in  1  level input; each 0->1 transition is one adjust step
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- alarm_en  in  1  alarm armed
- bcd_su, bcd_st, bcd_mu, bcd_mt, bcd_hu, bcd_ht  out  4 each  displayed time, units/tens
- pm  out  1  12-hour mode and hour >= 12; 0 in 24-hour mode
- sec_pulse  out  1  one-cycle tick strobe
- alarm  out  1  alarm ringing

## Operation
- **Time registers**
  - Seconds and minutes are BCD 00-59; hours are BCD 00-23.
  - Hours are always stored in 24-hour form.
- **Alarm registers**
  - Alarm minutes are 00-59 and alarm hours are 00-23.
  - Alarm seconds are implicitly 00.
- **Prescaler**
  - Counts 0..TICK_DIV-1 while adjust=0.
  - sec_pulse=1 during the cycle in which the count equals TICK_DIV-1.
  - The count wraps to 0 on that edge.
  - While adjust=1, the prescaler is held at 0 and sec_pulse=0.
- **Counting on sec_pulse**
  - Seconds increment.
  - On 59 -> 00, minutes increment.
  - On 59:59 -> 00:00, hours increment.
  - 23:59:59 wraps to 00:00:00.
- **Adjust**
  - Step edge = step & ~step_q, where step_q is step registered every cycle. An edge is acted on only while adjust=1.
  - field=00: clears seconds to 00. With target=1 it is a no-op.
  - field=01: increments minutes (time or alarm per target), 59 -> 00, with no carry into hours.
  - field=10: increments hours, 23 -> 00.
  - Adjust never carries between fields.
- **Display**
  - 24-hour mode: bcd_h* equals the stored hours.
  - 12-hour mode, hour mapping: 00 shows 12 with pm=0; 01-11 show unchanged with pm=0; 12 shows 12 with pm=1; 13-23 show hour-12 with pm=1.
  - In 12-hour mode bcd_ht is only ever 0 or 1.
  - Display is combinational from registers; mode_12h changes take effect immediately, with no state change.
- **Alarm FSM, states IDLE and RING**
  - IDLE -> RING: on a sec_pulse edge whose next time equals alarm_h:alarm_m:00, with alarm_en=1. The ring counter loads ALARM_SECS.
  - In RING, each sec_pulse decrements the ring counter.
  - RING -> IDLE: when the counter reaches 0, or when alarm_en=0 on any edge.
  - alarm = (state == RING).
  - Reaching the alarm time via adjust never triggers the alarm.
  - While adjust=1 in RING, the counter is frozen because there are no ticks.

## Timing
- **Reset (cr=0, asynchronous)**
  - Time = 00:00:00, alarm = 00:00, prescaler = 0, state = IDLE, ring counter = 0.
  - step_q = 1, so a step held high through reset does not fire.
- **Output values during reset**
  - bcd_* = 0 in 24-hour mode.
  - In 12-hour mode, hours display 12 with pm=0.
  - sec_pulse=0 and alarm=0.
- **Adjust latency:** a step edge sampled at clock edge N updates the field at edge N.
- **Tick timing**
  - The first tick after reset release occurs TICK_DIV cycles later; sec_pulse is high in cycle TICK_DIV-1, counting from 0.
  - Time registers update on the edge that ends the sec_pulse cycle.
  - alarm rises on that same edge.
- **adjust transitions**
  - Rising mid-count discards the partial second.
  - Falling restarts a full TICK_DIV period.
- **Simultaneous events**
  - alarm_en falling on the same edge as the trigger condition: the alarm does not start.
  - cr asserted mid-RING: alarm drops immediately, asynchronously.
- **step toggling:** at most one step per clock; a step held high produces exactly one increment.

## Test plan
- TICK_DIV=4, reset release: sec_pulse first high in cycle 3. After 240 cycles the time reads 00:01:00.
- Preset 23:59:58 via adjust, run 2 ticks -> 23:59:59, then 00:00:00. pm=0; in 12-hour mode hours read 12.
- Adjust minutes from 59 with one step -> 00 and hours unchanged. A step held high 10 cycles -> exactly one increment. field=00 step at 00:00:37 -> 00:00:00.
- mode_12h=1 with hours stepped through 00, 11, 12, 13, 23 -> displays 12/0, 11/0, 12/1, 01/1, 11/1 (hours/pm).
- Alarm 00:01, alarm_en=1, ALARM_SECS=3, run from 00:00:58:
  - alarm rises on the edge to 00:01:00;
  - after 3 further ticks, at 00:01:03, alarm falls.
  - A repeat run with alarm_en dropped mid-ring -> alarm falls the next edge.
- Step time onto 00:01:00 in adjust mode with the alarm armed -> alarm stays 0. Assert cr mid-ring -> all outputs at reset values immediately.

Source files
------------

// File: rtl/timekeeper_bcd_if.sv
// Control inputs and display/alarm outputs of the BCD time-of-day core.
// The master side drives controls and observes the display; the slave is the core.
interface timekeeper_bcd_if;
    logic       adjust;
    logic       target;
    logic [1:0] field;
    logic       step;
    logic       mode_12h;
    logic       alarm_en;
    logic [3:0] bcd_su;
    logic [3:0] bcd_st;
    logic [3:0] bcd_mu;
    logic [3:0] bcd_mt;
    logic [3:0] bcd_hu;
    logic [3:0] bcd_ht;
    logic       pm;
    logic       sec_pulse;
    logic       alarm;

    modport master (
        output adjust, target, field, step, mode_12h, alarm_en,
        input  bcd_su, bcd_st, bcd_mu, bcd_mt, bcd_hu, bcd_ht, pm, sec_pulse, alarm
    );

    modport slave (
        input  adjust, target, field, step, mode_12h, alarm_en,
        output bcd_su, bcd_st, bcd_mu, bcd_mt, bcd_hu, bcd_ht, pm, sec_pulse, alarm
    );
endinterface

// File: rtl/timekeeper_bcd.sv
// BCD time-of-day core: prescaled 1 Hz tick, hh:mm:ss counters, step adjust, 12/24 h display, timed alarm.
// Time and adjust updates land on the clock edge that samples them; display is combinational, no backpressure.
module timekeeper_bcd #(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 60
) (
    input  logic            clk,
    input  logic            cr,
    timekeeper_bcd_if.slave bus
);
    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]       RING_LOAD = 8'(ALARM_SECS);

    typedef enum logic {
        IDLE,
        RING
    } state_t;

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       hr_q, hr_d;
    logic [7:0]       alm_min_q, alm_min_d;
    logic [7:0]       alm_hr_q, alm_hr_d;
    logic             step_q;
    state_t           state_q, state_d;
    logic [7:0]       ring_q, ring_d;

    logic             tick;
    logic             step_edge;
    logic             sec_wrap;
    logic             min_wrap;
    logic             alarm_hit;
    logic [7:0]       sec_nx, min_nx, hr_nx;
    logic [7:0]       hr_disp;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick      = ~bus.adjust & (presc_q == CNT_LAST);
    assign step_edge = bus.step & ~step_q;

    always_comb begin
        presc_d = presc_q + CNT_W'(1);
        if (bus.adjust || tick) begin
            presc_d = '0;
        end
    end

    assign sec_wrap  = (sec_q == 8'h59);
    assign min_wrap  = (min_q == 8'h59);
    assign sec_nx    = bcd_inc(sec_q, 8'h59);
    assign min_nx    = sec_wrap ? bcd_inc(min_q, 8'h59) : min_q;
    assign hr_nx     = (sec_wrap && min_wrap) ? bcd_inc(hr_q, 8'h23) : hr_q;
    assign alarm_hit = bus.alarm_en && (sec_nx == 8'h00) &&
                       (min_nx == alm_min_q) && (hr_nx == alm_hr_q);

    // Ticks never coincide with adjust steps because the prescaler is held in adjust mode.
    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        hr_d      = hr_q;
        alm_min_d = alm_min_q;
        alm_hr_d  = alm_hr_q;
        if (tick) begin
            sec_d = sec_nx;
            min_d = min_nx;
            hr_d  = hr_nx;
        end else if (bus.adjust && step_edge) begin
            case (bus.field)
                2'b00: begin
                    if (!bus.target) begin
                        sec_d = 8'h00;
                    end
                end
                2'b01: begin
                    if (bus.target) begin
                        alm_min_d = bcd_inc(alm_min_q, 8'h59);
                    end else begin
                        min_d = bcd_inc(min_q, 8'h59);
                    end
                end
                2'b10: begin
                    if (bus.target) begin
                        alm_hr_d = bcd_inc(alm_hr_q, 8'h23);
                    end else begin
                        hr_d = bcd_inc(hr_q, 8'h23);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        case (state_q)
            IDLE: begin
                if (tick && alarm_hit) begin
                    state_d = RING;
                    ring_d  = RING_LOAD;
                end
            end
            RING: begin
                if (!bus.alarm_en) begin
                    state_d = IDLE;
                    ring_d  = 8'd0;
                end else if (tick) begin
                    ring_d = ring_q - 8'd1;
                    if (ring_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ring_d  = 8'd0;
            end
        endcase
    end

    // step_q resets high so a step held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            presc_q   <= '0;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hr_q      <= 8'h00;
            alm_min_q <= 8'h00;
            alm_hr_q  <= 8'h00;
            step_q    <= 1'b1;
            state_q   <= IDLE;
            ring_q    <= 8'd0;
        end else begin
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            alm_min_q <= alm_min_d;
            alm_hr_q  <= alm_hr_d;
            step_q    <= bus.step;
            state_q   <= state_d;
            ring_q    <= ring_d;
        end
    end

    always_comb begin
        hr_disp = hr_q;
        if (bus.mode_12h) begin
            case (hr_q)
                8'h00:   hr_disp = 8'h12;
                8'h13:   hr_disp = 8'h01;
                8'h14:   hr_disp = 8'h02;
                8'h15:   hr_disp = 8'h03;
                8'h16:   hr_disp = 8'h04;
                8'h17:   hr_disp = 8'h05;
                8'h18:   hr_disp = 8'h06;
                8'h19:   hr_disp = 8'h07;
                8'h20:   hr_disp = 8'h08;
                8'h21:   hr_disp = 8'h09;
                8'h22:   hr_disp = 8'h10;
                8'h23:   hr_disp = 8'h11;
                default: hr_disp = hr_q;
            endcase
        end
    end

    assign bus.bcd_su    = sec_q[3:0];
    assign bus.bcd_st    = sec_q[7:4];
    assign bus.bcd_mu    = min_q[3:0];
    assign bus.bcd_mt    = min_q[7:4];
    assign bus.bcd_hu    = hr_disp[3:0];
    assign bus.bcd_ht    = hr_disp[7:4];
    assign bus.pm        = bus.mode_12h & (hr_q >= 8'h12);
    assign bus.sec_pulse = tick;
    assign bus.alarm     = (state_q == RING);
endmodule

// File: tb/tb_timekeeper_bcd.sv
// Bench for timekeeper_bcd: directed scenarios plus random control traffic,
// every cycle compared against a seconds-of-day reference model.
module tb_timekeeper_bcd;
    localparam int TICK_DIV   = 4;
    localparam int ALARM_SECS = 3;
    localparam int DAY        = 86400;

    logic clk = 1'b0;
    logic cr;

    timekeeper_bcd_if bus();

    timekeeper_bcd #(
        .TICK_DIV   (TICK_DIV),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk (clk),
        .cr  (cr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_t;
    int m_ah;
    int m_am;
    int m_pc;
    int m_rc;
    bit m_stepq;
    bit m_ring;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t     = 0;
        m_ah    = 0;
        m_am    = 0;
        m_pc    = 0;
        m_rc    = 0;
        m_stepq = 1'b1;
        m_ring  = 1'b0;
    endtask

    function automatic bit model_pulse();
        return !bus.adjust && (m_pc == TICK_DIV - 1);
    endfunction

    function automatic logic [31:0] model_outs();
        int h, m, s, dh;
        bit pmv;
        h  = m_t / 3600;
        m  = (m_t / 60) % 60;
        s  = m_t % 60;
        dh = h;
        if (bus.mode_12h) begin
            dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        end
        pmv = bus.mode_12h && (h >= 12);
        return {5'd0, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), pmv, model_pulse(), m_ring};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {5'd0, bus.bcd_ht, bus.bcd_hu, bus.bcd_mt, bus.bcd_mu,
                bus.bcd_st, bus.bcd_su, bus.pm, bus.sec_pulse, bus.alarm};
    endfunction

    task automatic model_edge();
        bit pulse, stp_edge;
        int nt, h, m, s;
        pulse    = model_pulse();
        stp_edge = bus.step && !m_stepq;
        m_stepq  = bus.step;
        m_pc     = bus.adjust ? 0 : (m_pc + 1) % TICK_DIV;
        nt       = (m_t + 1) % DAY;
        if (m_ring) begin
            if (!bus.alarm_en) begin
                m_ring = 1'b0;
            end else if (pulse) begin
                m_rc--;
                if (m_rc == 0) m_ring = 1'b0;
            end
        end else if (pulse && bus.alarm_en && nt == m_ah * 3600 + m_am * 60) begin
            m_ring = 1'b1;
            m_rc   = ALARM_SECS;
        end
        if (pulse) m_t = nt;
        if (bus.adjust && stp_edge) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            s = m_t % 60;
            case (bus.field)
                2'd0: if (!bus.target) s = 0;
                2'd1: if (bus.target) m_am = (m_am + 1) % 60; else m = (m + 1) % 60;
                2'd2: if (bus.target) m_ah = (m_ah + 1) % 24; else h = (h + 1) % 24;
                default: ;
            endcase
            m_t = h * 3600 + m * 60 + s;
        end
    endtask

    // Entered and left at a falling edge; inputs change only between calls.
    task automatic cycle();
        #1;
        chk("outs", dut_outs(), model_outs());
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic step_n(input logic [1:0] fld, input logic tgt, input int n);
        bus.adjust = 1'b1;
        bus.field  = fld;
        bus.target = tgt;
        for (int i = 0; i < n; i++) begin
            bus.step = 1'b1;
            cycle();
            bus.step = 1'b0;
            cycle();
        end
    endtask

    function automatic logic [23:0] hms();
        return {bus.bcd_ht, bus.bcd_hu, bus.bcd_mt, bus.bcd_mu, bus.bcd_st, bus.bcd_su};
    endfunction

    int hr_tgt[5] = '{0, 11, 12, 13, 23};
    int hr_dsp[5] = '{12, 11, 12, 1, 11};
    bit hr_pm[5]  = '{0, 0, 1, 1, 1};

    initial begin
        int cur;
        cr           = 1'b0;
        bus.adjust   = 1'b0;
        bus.target   = 1'b0;
        bus.field    = 2'd0;
        bus.step     = 1'b0;
        bus.mode_12h = 1'b0;
        bus.alarm_en = 1'b0;
        model_reset();
        #1;
        chk("rst_24h", dut_outs(), 32'd0);
        bus.mode_12h = 1'b1;
        #1;
        chk("rst_12h", dut_outs(), {5'd0, 4'd1, 4'd2, 16'd0, 3'd0});
        bus.mode_12h = 1'b0;
        @(negedge clk);
        cr = 1'b1;

        for (int i = 0; i < 4; i++) begin
            #1;
            chk("first_tick", bus.sec_pulse, (i == 3));
            cycle();
        end
        run(236);
        chk("one_minute", hms(), 24'h000100);

        step_n(2'd2, 1'b0, 23);
        step_n(2'd1, 1'b0, 58);
        step_n(2'd0, 1'b0, 1);
        bus.adjust = 1'b0;
        run(58 * TICK_DIV);
        chk("preset", hms(), 24'h235958);
        run(TICK_DIV);
        chk("last_sec", hms(), 24'h235959);
        run(TICK_DIV);
        chk("midnight", hms(), 24'h000000);
        chk("midnight_pm", bus.pm, 1'b0);
        bus.mode_12h = 1'b1;
        #1;
        chk("midnight_12h", {bus.bcd_ht, bus.bcd_hu, bus.pm}, {4'd1, 4'd2, 1'b0});
        bus.mode_12h = 1'b0;

        step_n(2'd2, 1'b0, 5);
        step_n(2'd1, 1'b0, 59);
        chk("min_preset", hms(), 24'h055900);
        step_n(2'd1, 1'b0, 1);
        chk("min_nocarry", hms(), 24'h050000);
        bus.step = 1'b1;
        run(10);
        bus.step = 1'b0;
        cycle();
        chk("held_step", hms(), 24'h050100);
        bus.adjust = 1'b0;
        run(37 * TICK_DIV);
        chk("sec37", hms(), 24'h050137);
        step_n(2'd0, 1'b0, 1);
        chk("sec_clear", hms(), 24'h050100);

        bus.mode_12h = 1'b1;
        cur = 5;
        for (int k = 0; k < 5; k++) begin
            step_n(2'd2, 1'b0, (hr_tgt[k] - cur + 24) % 24);
            cur = hr_tgt[k];
            chk("h12_map", {bus.bcd_ht, bus.bcd_hu, bus.pm},
                {4'(hr_dsp[k] / 10), 4'(hr_dsp[k] % 10), hr_pm[k]});
        end
        bus.mode_12h = 1'b0;

        step_n(2'd1, 1'b1, 1);
        step_n(2'd2, 1'b0, 1);
        step_n(2'd1, 1'b0, 59);
        step_n(2'd0, 1'b0, 1);
        chk("alarm_preset", hms(), 24'h000000);
        bus.alarm_en = 1'b1;
        bus.adjust   = 1'b0;
        run(58 * TICK_DIV);
        chk("pre_alarm", {hms(), 7'd0, bus.alarm}, {24'h000058, 8'd0});
        run(2 * TICK_DIV);
        chk("alarm_rise", {hms(), 7'd0, bus.alarm}, {24'h000100, 8'd1});
        run(2 * TICK_DIV);
        chk("alarm_hold", {hms(), 7'd0, bus.alarm}, {24'h000102, 8'd1});
        run(TICK_DIV);
        chk("alarm_fall", {hms(), 7'd0, bus.alarm}, {24'h000103, 8'd0});

        step_n(2'd1, 1'b0, 59);
        step_n(2'd0, 1'b0, 1);
        bus.adjust = 1'b0;
        run(60 * TICK_DIV);
        chk("ring2_rise", bus.alarm, 1'b1);
        run(TICK_DIV);
        chk("ring2_hold", bus.alarm, 1'b1);
        bus.alarm_en = 1'b0;
        cycle();
        chk("en_drop", bus.alarm, 1'b0);
        bus.alarm_en = 1'b1;

        step_n(2'd1, 1'b0, 59);
        step_n(2'd0, 1'b0, 1);
        step_n(2'd1, 1'b0, 1);
        chk("adj_onto_alarm", {hms(), 7'd0, bus.alarm}, {24'h000100, 8'd0});
        bus.adjust = 1'b0;
        run(2 * TICK_DIV);
        chk("adj_no_ring", bus.alarm, 1'b0);

        step_n(2'd1, 1'b0, 59);
        step_n(2'd0, 1'b0, 1);
        bus.adjust = 1'b0;
        run(60 * TICK_DIV);
        chk("ring3_rise", bus.alarm, 1'b1);
        #2;
        cr = 1'b0;
        #1;
        chk("cr_async", dut_outs(), 32'd0);
        model_reset();
        @(negedge clk);
        cr = 1'b1;

        step_n(2'd1, 1'b1, 1);
        bus.adjust = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) bus.adjust = ~bus.adjust;
            bus.step   = ($urandom_range(0, 3) == 0);
            bus.field  = 2'($urandom_range(0, 3));
            bus.target = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) bus.mode_12h = ~bus.mode_12h;
            bus.alarm_en = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
